bp_update_queue: RTL and testbench
==================================

# bp_update_queue

Buffers in-flight branch predictions between predictor lookup and branch resolution, then drives the predictor's training port. Each lookup pushes its index and predicted direction. Each in-order resolution pops the oldest entry and emits a registered update (index, actual outcome, mispredict flag), which connects directly to the predictor's write index and branch-result inputs. The block also keeps saturating accuracy counters.

## Interface
- DEPTH, 8, queue entries; power of two, ≥2
- IDX_W, 32, branch index width; matches the predictor's read/write index ports
- CNT_W, 32, width of the statistics counters
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all in-flight entries (pipeline squash)
- pred_valid_i  in  1  a prediction was issued this cycle
- pred_idx_i  in  IDX_W  index used for the lookup
- pred_taken_i  in  1  predicted direction (predictor output)
- pred_ready_o  out  1  queue can accept a push (not full)
- res_valid_i  in  1  oldest in-flight branch resolved this cycle
- res_taken_i  in  1  actual branch outcome
- upd_valid_o  out  1  update strobe to predictor
- upd_idx_o  out  IDX_W  update index (predictor write index)
- upd_taken_o  out  1  actual outcome (predictor branch result)
- upd_mispred_o  out  1  stored prediction != actual outcome
- count_o  out  $clog2(DEPTH+1)  current occupancy
- total_o  out  CNT_W  resolved branches, saturating
- mispred_cnt_o  out  CNT_W  mispredicted branches, saturating
- underflow_o  out  1  sticky: resolve seen while queue empty

## Operation
- Storage: circular buffer of DEPTH entries {idx, taken}. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in count_o.
- Push: occurs when pred_valid_i && pred_ready_o. Writes the entry at wr_ptr, then wr_ptr+1.
- pred_ready_o = (count_o != DEPTH). A push while full is dropped silently; no state change.
- Pop: occurs when res_valid_i && count_o != 0. Reads the entry at rd_ptr, then rd_ptr+1.
- Resolve with count_o == 0 sets underflow_o (sticky until rst_i). No pop, no update. This holds even if a push occurs in the same cycle: a pop only sees entries stored before that cycle.
- Simultaneous push and pop: both take effect and count_o is unchanged. When full, the push is still refused, because pred_ready_o depends only on current occupancy.
- On each pop, the next cycle drives:
  - upd_valid_o = 1
  - upd_idx_o = stored idx
  - upd_taken_o = res_taken_i
  - upd_mispred_o = stored taken ^ res_taken_i
- On cycles with no pop, upd_valid_o = 0. upd_idx_o, upd_taken_o and upd_mispred_o hold their last values.
- Counters: total_o increments on every pop. mispred_cnt_o increments when the popped entry mispredicts. Both saturate at 2^CNT_W−1 (no wrap).
- flush_i: next cycle, the pointers and count_o are 0. Push and resolve are ignored in the flush cycle: no update, no counter change, no underflow. The counters and underflow_o are not cleared.
- Priority: rst_i > flush_i > push/pop.

## Timing
- Reset values: count_o=0, pred_ready_o=1, upd_valid_o=0, upd_idx_o=0, upd_taken_o=0, upd_mispred_o=0, total_o=0, mispred_cnt_o=0, underflow_o=0. Pointers are 0.
- Reset mid-operation discards all entries. A pop in the reset cycle produces no update.
- pred_ready_o and count_o are registered-state-derived: no combinational path from any input.
- Update latency: exactly 1 cycle after the resolve edge. Back-to-back pops give back-to-back upd_valid_o pulses.
- Counters update in the same cycle upd_valid_o asserts.
- Pushed data is visible to a pop starting the following cycle (1-cycle push-to-pop).

## Test plan
- Reset, then push idx 0x10 taken=1, next cycle resolve res_taken=0:
  - one cycle later: upd_valid_o=1, upd_idx_o=0x10, upd_taken_o=0, upd_mispred_o=1
  - total_o=1, mispred_cnt_o=1
- Fill DEPTH=8 with idx 0..7, then attempt a ninth push:
  - pred_ready_o=0, count_o=8, ninth push dropped
  - eight resolves emit idx 0..7 in order, and count_o returns to 0
- Wrap-around: 20 interleaved push/pop pairs with occupancy held at 3:
  - FIFO order preserved across pointer wrap
  - count_o stays 3
- Resolve on an empty queue while a push occurs in the same cycle:
  - underflow_o=1 and stays set
  - no upd_valid_o
  - count_o=1
- Flush with 5 entries while res_valid_i=1:
  - next cycle count_o=0, no update, counters unchanged
  - a subsequent push/pop works normally
- CNT_W=3: 9 mispredicting pops:
  - total_o=7 and mispred_cnt_o=7 (saturated)
  - then rst_i mid-burst clears all outputs to reset values

Source files
------------

// File: rtl/bp_update_queue_if.sv
// Lookup/resolve/update bundle between the predictor pipeline and the update queue.
// The slave modport is the queue side; master is the pipeline/predictor side.
interface bp_update_queue_if #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 32,
    parameter int CNT_W = 32
);
    localparam int CB = $clog2(DEPTH + 1);

    logic             flush_i;
    logic             pred_valid_i;
    logic [IDX_W-1:0] pred_idx_i;
    logic             pred_taken_i;
    logic             pred_ready_o;
    logic             res_valid_i;
    logic             res_taken_i;
    logic             upd_valid_o;
    logic [IDX_W-1:0] upd_idx_o;
    logic             upd_taken_o;
    logic             upd_mispred_o;
    logic [CB-1:0]    count_o;
    logic [CNT_W-1:0] total_o;
    logic [CNT_W-1:0] mispred_cnt_o;
    logic             underflow_o;

    modport slave (
        input  flush_i, pred_valid_i, pred_idx_i, pred_taken_i, res_valid_i, res_taken_i,
        output pred_ready_o, upd_valid_o, upd_idx_o, upd_taken_o, upd_mispred_o,
               count_o, total_o, mispred_cnt_o, underflow_o
    );

    modport master (
        output flush_i, pred_valid_i, pred_idx_i, pred_taken_i, res_valid_i, res_taken_i,
        input  pred_ready_o, upd_valid_o, upd_idx_o, upd_taken_o, upd_mispred_o,
               count_o, total_o, mispred_cnt_o, underflow_o
    );
endinterface

// File: rtl/bp_update_queue.sv
// In-order queue of predictions; each resolve pops one entry and emits a registered update 1 cycle later.
// Pushes are refused (pred_ready_o low) when full; resolves on an empty queue only set sticky underflow.
module bp_update_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bp_update_queue_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CB    = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] r_idx_mem [DEPTH];
    logic [DEPTH-1:0] r_tkn_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CB-1:0]    r_count;
    logic             r_upd_valid;
    logic [IDX_W-1:0] r_upd_idx;
    logic             r_upd_taken;
    logic             r_upd_mispred;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_mis;

    assign w_full  = (r_count == CB'(DEPTH));
    assign w_empty = (r_count == '0);
    // Readiness and pop eligibility look only at occupancy before this edge.
    assign w_push  = bus.pred_valid_i && !w_full  && !bus.flush_i;
    assign w_pop   = bus.res_valid_i  && !w_empty && !bus.flush_i;
    assign w_mis   = r_tkn_mem[r_rd_ptr] ^ bus.res_taken_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_idx_mem[r_wr_ptr] <= bus.pred_idx_i;
            r_tkn_mem[r_wr_ptr] <= bus.pred_taken_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_upd_valid   <= 1'b0;
            r_upd_idx     <= '0;
            r_upd_taken   <= 1'b0;
            r_upd_mispred <= 1'b0;
            r_total       <= '0;
            r_mispred_cnt <= '0;
            r_underflow   <= 1'b0;
        end else if (bus.flush_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_upd_valid <= 1'b0;
        end else begin
            r_upd_valid <= w_pop;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_upd_idx     <= r_idx_mem[r_rd_ptr];
                r_upd_taken   <= bus.res_taken_i;
                r_upd_mispred <= w_mis;
                if (r_total != '1) r_total <= r_total + 1'b1;
                if (w_mis && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
            if (bus.res_valid_i && w_empty) r_underflow <= 1'b1;
        end
    end

    assign bus.pred_ready_o  = !w_full;
    assign bus.count_o       = r_count;
    assign bus.upd_valid_o   = r_upd_valid;
    assign bus.upd_idx_o     = r_upd_idx;
    assign bus.upd_taken_o   = r_upd_taken;
    assign bus.upd_mispred_o = r_upd_mispred;
    assign bus.total_o       = r_total;
    assign bus.mispred_cnt_o = r_mispred_cnt;
    assign bus.underflow_o   = r_underflow;
endmodule

// File: tb/tb_bp_update_queue.sv
// Queue-model scoreboard for a 32-bit-counter instance plus directed saturation/reset checks on a 3-bit-counter instance.
module tb_bp_update_queue;
    localparam int DEPTH = 8;
    localparam logic [31:0] MAX_A = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic a_rst = 1'b1;
    logic b_rst = 1'b1;
    always #5 clk = ~clk;

    bp_update_queue_if #(.DEPTH(DEPTH), .IDX_W(32), .CNT_W(32)) a_if ();
    bp_update_queue_if #(.DEPTH(DEPTH), .IDX_W(32), .CNT_W(3))  b_if ();

    bp_update_queue #(.DEPTH(DEPTH), .IDX_W(32), .CNT_W(32)) u_dut_a (
        .clk_i(clk), .rst_i(a_rst), .bus(a_if.slave));
    bp_update_queue #(.DEPTH(DEPTH), .IDX_W(32), .CNT_W(3)) u_dut_b (
        .clk_i(clk), .rst_i(b_rst), .bus(b_if.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of outstanding predictions.
    typedef struct { logic [31:0] idx; logic tk; } ent_t;
    ent_t        q[$];
    ent_t        e;
    bit          m_live = 0;
    bit          can_pop, can_push;
    logic        m_uv, m_ut, m_um, m_uf;
    logic [31:0] m_ui, m_tot, m_mc;

    always @(posedge clk) begin
        if (a_rst) begin
            q.delete();
            m_uv = 0; m_ui = 0; m_ut = 0; m_um = 0;
            m_tot = 0; m_mc = 0; m_uf = 0; m_live = 1;
        end else if (a_if.flush_i) begin
            q.delete();
            m_uv = 0;
        end else begin
            can_pop  = a_if.res_valid_i && (q.size() != 0);
            can_push = a_if.pred_valid_i && (q.size() < DEPTH);
            if (a_if.res_valid_i && q.size() == 0) m_uf = 1;
            m_uv = can_pop;
            if (can_pop) begin
                e    = q.pop_front();
                m_ui = e.idx;
                m_ut = a_if.res_taken_i;
                m_um = (e.tk != a_if.res_taken_i);
                if (m_tot != MAX_A) m_tot = m_tot + 1;
                if (m_um && m_mc != MAX_A) m_mc = m_mc + 1;
            end
            if (can_push) q.push_back('{a_if.pred_idx_i, a_if.pred_taken_i});
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("count",     64'(a_if.count_o),       64'(q.size()));
            check("ready",     64'(a_if.pred_ready_o),  64'(q.size() != DEPTH));
            check("upd_valid", 64'(a_if.upd_valid_o),   64'(m_uv));
            check("upd_idx",   64'(a_if.upd_idx_o),     64'(m_ui));
            check("upd_taken", 64'(a_if.upd_taken_o),   64'(m_ut));
            check("upd_mis",   64'(a_if.upd_mispred_o), 64'(m_um));
            check("total",     64'(a_if.total_o),       64'(m_tot));
            check("mis_cnt",   64'(a_if.mispred_cnt_o), 64'(m_mc));
            check("underflow", 64'(a_if.underflow_o),   64'(m_uf));
        end
    end

    task automatic drva(input logic rst, input logic fl, input logic pv, input logic [31:0] idx,
                        input logic pt, input logic rv, input logic rt);
        @(negedge clk);
        a_rst = rst; a_if.flush_i = fl;
        a_if.pred_valid_i = pv; a_if.pred_idx_i = idx; a_if.pred_taken_i = pt;
        a_if.res_valid_i = rv; a_if.res_taken_i = rt;
    endtask

    task automatic drvb(input logic rst, input logic pv, input logic [31:0] idx,
                        input logic pt, input logic rv, input logic rt);
        @(negedge clk);
        b_rst = rst; b_if.flush_i = 1'b0;
        b_if.pred_valid_i = pv; b_if.pred_idx_i = idx; b_if.pred_taken_i = pt;
        b_if.res_valid_i = rv; b_if.res_taken_i = rt;
    endtask

    initial begin
        a_if.flush_i = 0; a_if.pred_valid_i = 0; a_if.pred_idx_i = 0; a_if.pred_taken_i = 0;
        a_if.res_valid_i = 0; a_if.res_taken_i = 0;
        b_if.flush_i = 0; b_if.pred_valid_i = 0; b_if.pred_idx_i = 0; b_if.pred_taken_i = 0;
        b_if.res_valid_i = 0; b_if.res_taken_i = 0;

        drva(1, 0, 0, 0, 0, 0, 0);
        drva(1, 0, 0, 0, 0, 0, 0);
        drva(0, 0, 0, 0, 0, 0, 0);
        check("rst_count", 64'(a_if.count_o), 64'd0);
        check("rst_ready", 64'(a_if.pred_ready_o), 64'd1);
        check("rst_uv",    64'(a_if.upd_valid_o), 64'd0);

        // Single mispredicted branch.
        drva(0, 0, 1, 32'h10, 1, 0, 0);
        drva(0, 0, 0, 0, 0, 1, 0);
        drva(0, 0, 0, 0, 0, 0, 0);
        check("t1_uv",  64'(a_if.upd_valid_o), 64'd1);
        check("t1_idx", 64'(a_if.upd_idx_o), 64'h10);
        check("t1_tk",  64'(a_if.upd_taken_o), 64'd0);
        check("t1_mis", 64'(a_if.upd_mispred_o), 64'd1);
        check("t1_tot", 64'(a_if.total_o), 64'd1);
        check("t1_mc",  64'(a_if.mispred_cnt_o), 64'd1);

        // Fill, overflow attempt, drain in order.
        for (int i = 0; i < 8; i++) drva(0, 0, 1, 32'(i), 1'(i), 0, 0);
        drva(0, 0, 1, 32'h99, 1, 0, 0);
        drva(0, 0, 0, 0, 0, 0, 0);
        check("full_count", 64'(a_if.count_o), 64'd8);
        check("full_ready", 64'(a_if.pred_ready_o), 64'd0);
        for (int i = 0; i <= 8; i++) begin
            drva(0, 0, 0, 0, 0, 1'(i < 8), 0);
            if (i > 0) check("drain_idx", 64'(a_if.upd_idx_o), 64'(i - 1));
        end
        drva(0, 0, 0, 0, 0, 0, 0);
        check("drain_count", 64'(a_if.count_o), 64'd0);
        check("t2_tot", 64'(a_if.total_o), 64'd9);
        check("t2_mc",  64'(a_if.mispred_cnt_o), 64'd5);

        // Occupancy held at 3 across pointer wrap.
        for (int i = 0; i < 3; i++) drva(0, 0, 1, 32'(100 + i), 0, 0, 0);
        for (int i = 0; i <= 20; i++) begin
            drva(0, 0, 1'(i < 20), 32'(103 + i), 0, 1'(i < 20), 0);
            if (i > 0) begin
                check("wrap_idx",   64'(a_if.upd_idx_o), 64'(100 + i - 1));
                check("wrap_count", 64'(a_if.count_o), 64'd3);
            end
        end
        for (int i = 0; i < 3; i++) drva(0, 0, 0, 0, 0, 1, 0);
        drva(0, 0, 0, 0, 0, 0, 0);
        check("wrap_last", 64'(a_if.upd_idx_o), 64'd122);
        check("wrap_empty", 64'(a_if.count_o), 64'd0);

        // Resolve on empty with a same-cycle push.
        drva(0, 0, 1, 32'h55, 1, 1, 0);
        drva(0, 0, 0, 0, 0, 0, 0);
        check("uf_set",   64'(a_if.underflow_o), 64'd1);
        check("uf_uv",    64'(a_if.upd_valid_o), 64'd0);
        check("uf_count", 64'(a_if.count_o), 64'd1);
        drva(0, 0, 0, 0, 0, 1, 0);
        drva(0, 0, 0, 0, 0, 0, 0);
        check("uf_sticky", 64'(a_if.underflow_o), 64'd1);
        check("uf_idx",    64'(a_if.upd_idx_o), 64'h55);

        // Flush with 5 entries while resolving and pushing.
        for (int i = 0; i < 5; i++) drva(0, 0, 1, 32'(200 + i), 1, 0, 0);
        drva(0, 1, 1, 32'h300, 1, 1, 0);
        drva(0, 0, 0, 0, 0, 0, 0);
        check("fl_count", 64'(a_if.count_o), 64'd0);
        check("fl_uv",    64'(a_if.upd_valid_o), 64'd0);
        check("fl_tot",   64'(a_if.total_o), 64'd33);
        check("fl_mc",    64'(a_if.mispred_cnt_o), 64'd6);
        drva(0, 0, 1, 32'h77, 0, 0, 0);
        drva(0, 0, 0, 0, 0, 1, 0);
        drva(0, 0, 0, 0, 0, 0, 0);
        check("pf_idx", 64'(a_if.upd_idx_o), 64'h77);
        check("pf_mis", 64'(a_if.upd_mispred_o), 64'd0);
        check("pf_tot", 64'(a_if.total_o), 64'd34);

        // 3-bit counters: saturation, then reset during a pop.
        drvb(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drvb(0, 1, 32'(i), 1, 0, 0);
            drvb(0, 0, 0, 0, 1, 0);
        end
        drvb(0, 0, 0, 0, 0, 0);
        check("sat_tot", 64'(b_if.total_o), 64'd7);
        check("sat_mc",  64'(b_if.mispred_cnt_o), 64'd7);
        check("sat_idx", 64'(b_if.upd_idx_o), 64'd8);
        drvb(0, 1, 32'h5, 1, 0, 0);
        drvb(1, 0, 0, 0, 1, 0);
        drvb(0, 0, 0, 0, 0, 0);
        check("br_count", 64'(b_if.count_o), 64'd0);
        check("br_ready", 64'(b_if.pred_ready_o), 64'd1);
        check("br_uv",    64'(b_if.upd_valid_o), 64'd0);
        check("br_idx",   64'(b_if.upd_idx_o), 64'd0);
        check("br_tk",    64'(b_if.upd_taken_o), 64'd0);
        check("br_mis",   64'(b_if.upd_mispred_o), 64'd0);
        check("br_tot",   64'(b_if.total_o), 64'd0);
        check("br_mc",    64'(b_if.mispred_cnt_o), 64'd0);
        check("br_uf",    64'(b_if.underflow_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
